// File: rtl/com_uart.sv
// com_uart: COM-bus UART with TX/RX FIFOs, 8N1 framing, level irq.
// Optional loopback (CTRL[2]) when COM_UART_LOOPBACK_EN is defined.
module com_uart #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RESET  = 8'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] com_addr,
  input  logic [7:0] com_wr,
  input  logic       com_wr_en,
  input  logic       com_rd_en,
  output logic [7:0] com_rd,
  output logic       com_interrupt,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef COM_UART_LOOPBACK_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // register decode
  logic [7:0] off;
  logic       hit;
  logic       sel_data;
  logic       sel_stat;
  logic       sel_ctrl;
  logic       sel_baud;

  assign off      = com_addr - BASE_ADDR;
  assign hit      = (off[7:2] == 6'd0);
  assign sel_data = hit && (off[1:0] == 2'd0);
  assign sel_stat = hit && (off[1:0] == 2'd1);
  assign sel_ctrl = hit && (off[1:0] == 2'd2);
  assign sel_baud = hit && (off[1:0] == 2'd3);

  // control / status state
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [7:0]    baud_q, baud_d;
  logic          ovr_q, ovr_d;
  logic          fe_q, fe_d;
  logic          irq_q, irq_d;

  // TX FIFO
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_wp_d;
  logic [AW:0] tx_rp_q, tx_rp_d;
  logic        tx_empty;
  logic        tx_full;
  logic        tx_push;
  logic        tx_pop;
  logic [7:0]  tx_head;

  // RX FIFO
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp_q, rx_wp_d;
  logic [AW:0] rx_rp_q, rx_rp_d;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_valid;
  logic        rx_push;
  logic        rx_push_ok;
  logic        rx_pop;
  logic [7:0]  rx_head;

  // TX serializer
  state_e     tx_state_q, tx_state_d;
  logic [7:0] tx_cnt_q, tx_cnt_d;
  logic [7:0] tx_div_q, tx_div_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       txd_q, txd_d;
  logic       tx_tick;
  logic       tx_busy;

  // RX deserializer
  logic       rx_src;
  logic       rx_s1_q;
  logic       rx_s2_q;
  logic       rx_prev_q;
  state_e     rx_state_q, rx_state_d;
  logic [7:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       fe_set;
  logic       ovr_set;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                    (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
  assign tx_push  = com_wr_en && sel_data && !tx_full;
  assign tx_busy  = (tx_state_q != S_IDLE);

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                    (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];
  assign rx_pop   = com_rd_en && sel_data && rx_valid;
  // a same-cycle pop frees the slot the push lands in
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign ovr_set    = rx_push && rx_full && !rx_pop;

`ifdef COM_UART_LOOPBACK_EN
  assign rx_src   = ctrl_q[2] ? txd_q : uart_rxd;
  assign uart_txd = ctrl_q[2] ? 1'b1 : txd_q;
`else
  assign rx_src   = uart_rxd;
  assign uart_txd = txd_q;
`endif

  assign com_interrupt = irq_q;

  // read mux, combinational from address
  always_comb begin
    com_rd = 8'h00;
    if (hit) begin
      unique case (off[1:0])
        2'd0: com_rd = rx_valid ? rx_head : 8'h00;
        2'd1: com_rd = {1'b0, tx_busy, fe_q, ovr_q,
                        rx_full, rx_valid, tx_empty, tx_full};
        2'd2: com_rd = {{(8-CW){1'b0}}, ctrl_q};
        2'd3: com_rd = baud_q;
      endcase
    end
  end

  // register writes, sticky flags and interrupt condition
  always_comb begin
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    ovr_d  = ovr_q;
    fe_d   = fe_q;
    if (com_wr_en && sel_ctrl) ctrl_d = com_wr[CW-1:0];
    if (com_wr_en && sel_baud) baud_d = com_wr;
    if (com_rd_en && sel_stat) begin
      ovr_d = 1'b0;
      fe_d  = 1'b0;
    end
    if (ovr_set) ovr_d = 1'b1;
    if (fe_set)  fe_d  = 1'b1;
    irq_d = (ctrl_q[0] && tx_empty && !tx_busy) ||
            (ctrl_q[1] && rx_valid);
  end

  // FIFO pointer updates
  always_comb begin
    tx_wp_d = tx_push    ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d = tx_pop     ? tx_rp_q + 1'b1 : tx_rp_q;
    rx_wp_d = rx_push_ok ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d = rx_pop     ? rx_rp_q + 1'b1 : rx_rp_q;
  end

  // TX next state: period latched per bit so BAUD edits land on a boundary
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 8'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    tx_tick    = (tx_cnt_q == tx_div_q);
    unique case (tx_state_q)
      S_IDLE: begin
        txd_d    = 1'b1;
        tx_cnt_d = 8'd0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          txd_d      = 1'b0;
          tx_div_d   = baud_q;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_tick) begin
          tx_cnt_d   = 8'd0;
          tx_div_d   = baud_q;
          txd_d      = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[7:1]};
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = 8'd0;
          tx_div_d = baud_q;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tx_tick) begin
          tx_cnt_d = 8'd0;
          tx_div_d = baud_q;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            txd_d      = 1'b0;
            tx_state_d = S_START;
          end else begin
            txd_d      = 1'b1;
            tx_state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // RX next state: start at half period, then one full period per sample
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 8'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = 8'd0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == {1'b0, baud_q[7:1]}) begin
          rx_cnt_d   = 8'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == baud_q) begin
          rx_cnt_d = 8'd0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == baud_q) begin
          rx_cnt_d   = 8'd0;
          rx_push    = rx_s2_q;
          fe_set     = !rx_s2_q;
          rx_state_d = S_IDLE;
        end
      end
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem[i] <= 8'h00;
        rx_mem[i] <= 8'h00;
      end
    end else begin
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= com_wr;
      if (rx_push_ok) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end
  end

  // control registers, flags, pointers, interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      baud_q  <= DIV_RESET;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      irq_q   <= 1'b0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      baud_q  <= baud_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      irq_q   <= irq_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
    end
  end

  // TX FSM state; txd idles high and snaps high on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 8'd0;
      tx_div_q   <= 8'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  // RX synchronizer and FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 8'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
    end else begin
      rx_s1_q    <= rx_src;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

endmodule

// File: tb/tb_com_uart.sv
// tb_com_uart: randomized self-checking bench for com_uart.
// Reference: frame/queue model built from the register and line rules.
module tb_com_uart;

  localparam logic [7:0] BASE  = 8'h10;
  localparam int         DEPTH = 4;
  localparam int         BW    = 4;
  localparam logic [7:0] A_DATA = BASE;
  localparam logic [7:0] A_STAT = BASE + 8'd1;
  localparam logic [7:0] A_CTRL = BASE + 8'd2;
  localparam logic [7:0] A_BAUD = BASE + 8'd3;
`ifdef COM_UART_LOOPBACK_EN
  localparam logic [7:0] CTRL_MASK = 8'h07;
`else
  localparam logic [7:0] CTRL_MASK = 8'h03;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] com_addr = 8'h00;
  logic [7:0] com_wr = 8'h00;
  logic       com_wr_en = 1'b0;
  logic       com_rd_en = 1'b0;
  logic [7:0] com_rd;
  logic       com_interrupt;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;

  int n_run  = 0;
  int n_fail = 0;

  com_uart #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DIV_RESET (8'd15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .com_addr     (com_addr),
    .com_wr       (com_wr),
    .com_wr_en    (com_wr_en),
    .com_rd_en    (com_rd_en),
    .com_rd       (com_rd),
    .com_interrupt(com_interrupt),
    .uart_rxd     (uart_rxd),
    .uart_txd     (uart_txd)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog run did not finish");
    $fatal(1, "watchdog");
  end

  // expected line waveform of one 8N1 frame, bw clocks per bit
  function automatic logic [39:0] tx_wave(input logic [7:0] b);
    logic [9:0]  fr;
    logic [39:0] w;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) w[k] = fr[k / BW];
    return w;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    com_addr  = a;
    com_wr    = d;
    com_wr_en = 1'b1;
    @(posedge clk);
    #1 com_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input bit pop,
                    output logic [7:0] d);
    @(negedge clk);
    com_addr  = a;
    com_rd_en = pop;
    #1 d = com_rd;
    @(posedge clk);
    #1 com_rd_en = 1'b0;
  endtask

  // wait up to max_wait negedges for a start bit, then sample 40 clocks
  task automatic capture(input int max_wait, output logic [39:0] v,
                         output bit ok);
    ok = 1'b0;
    v  = '1;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      v[0] = 1'b0;
      for (int k = 1; k < 40; k++) begin
        @(negedge clk);
        v[k] = uart_txd;
      end
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rxd = fr[k];
      repeat (BW - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    logic [7:0] exp [4];
    exp[0] = 8'h00;
    exp[1] = 8'h02;
    exp[2] = 8'h00;
    exp[3] = 8'h0F;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if (uart_txd !== 1'b1 || com_interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lines txd=%b irq=%b want 1/0",
               uart_txd, com_interrupt);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 8'(i), 1'b0, v);
      n_run++;
      if (v !== exp[i]) begin
        n_fail++;
        $display("FAIL reset_reg%0d got %h want %h", i, v, exp[i]);
      end
    end
  endtask

  task automatic test_regs;
    logic [7:0] v;
    logic [7:0] r;
    wr(A_STAT, 8'hFF);
    rd(A_STAT, 1'b0, v);
    n_run++;
    if (v !== 8'h02) begin
      n_fail++;
      $display("FAIL status_wr_ignored got %h want 02", v);
    end
    rd(A_DATA, 1'b1, v);
    rd(A_STAT, 1'b0, r);
    n_run++;
    if (v !== 8'h00 || r !== 8'h02) begin
      n_fail++;
      $display("FAIL rd_empty got %h/%h want 00/02", v, r);
    end
    rd(BASE + 8'd4, 1'b0, v);
    rd(BASE - 8'd1, 1'b0, r);
    n_run++;
    if (v !== 8'h00 || r !== 8'h00) begin
      n_fail++;
      $display("FAIL out_of_window got %h/%h want 00/00", v, r);
    end
    r = 8'($urandom);
    wr(A_CTRL, r);
    rd(A_CTRL, 1'b0, v);
    n_run++;
    if (v !== (r & CTRL_MASK)) begin
      n_fail++;
      $display("FAIL ctrl_mask got %h want %h", v, r & CTRL_MASK);
    end
    wr(A_CTRL, 8'h00);
    r = 8'($urandom);
    wr(A_BAUD, r);
    rd(A_BAUD, 1'b0, v);
    n_run++;
    if (v !== r) begin
      n_fail++;
      $display("FAIL baud_rw got %h want %h", v, r);
    end
    wr(A_BAUD, 8'(BW - 1));
  endtask

  task automatic test_irq_tx;
    wr(A_CTRL, 8'h01);
    repeat (2) @(negedge clk);
    n_run++;
    if (com_interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_tx_empty got %b want 1", com_interrupt);
    end
    wr(A_CTRL, 8'h00);
    repeat (2) @(negedge clk);
    n_run++;
    if (com_interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_off got %b want 0", com_interrupt);
    end
  endtask

  task automatic test_tx_frame;
    logic [7:0]  b;
    logic [7:0]  v;
    logic [39:0] w;
    bit          ok;
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'hA5 : 8'($urandom);
      fork
        wr(A_DATA, b);
        capture(6, w, ok);
      join
      n_run++;
      if (!ok || w !== tx_wave(b)) begin
        n_fail++;
        $display("FAIL tx_frame b=%h got %h want %h",
                 b, w, tx_wave(b));
      end
      rd(A_STAT, 1'b0, v);
      n_run++;
      if (v[6] !== 1'b0 || uart_txd !== 1'b1) begin
        n_fail++;
        $display("FAIL tx_done busy=%b txd=%b want 0/1",
                 v[6], uart_txd);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  q [6];
    logic [39:0] w [DEPTH+1];
    bit          ok [DEPTH+1];
    logic [7:0]  v;
    bit          hi;
    for (int i = 0; i < 6; i++) q[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 6; i++) wr(A_DATA, q[i]);
        rd(A_STAT, 1'b0, v);
        n_run++;
        if ((v & 8'h43) !== 8'h41) begin
          n_fail++;
          $display("FAIL burst_status got %h want x1xxxx01", v);
        end
      end
      begin
        capture(8, w[0], ok[0]);
        for (int i = 1; i <= DEPTH; i++) capture(1, w[i], ok[i]);
        hi = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (uart_txd !== 1'b1) hi = 1'b0;
        end
      end
    join
    for (int i = 0; i <= DEPTH; i++) begin
      n_run++;
      if (!ok[i] || w[i] !== tx_wave(q[i])) begin
        n_fail++;
        $display("FAIL burst_frame%0d ok=%0d got %h want %h",
                 i, ok[i], w[i], tx_wave(q[i]));
      end
    end
    n_run++;
    if (!hi) begin
      n_fail++;
      $display("FAIL burst_drop got line activity want idle");
    end
  endtask

  task automatic test_rx_frame;
    logic [7:0] b;
    logic [7:0] v;
    wr(A_CTRL, 8'h02);
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? 8'h3C : 8'($urandom);
      rx_send(b, 1'b1);
      rd(A_STAT, 1'b0, v);
      n_run++;
      if (v[2] !== 1'b1 || com_interrupt !== 1'b1) begin
        n_fail++;
        $display("FAIL rx_valid_irq got %b/%b want 1/1",
                 v[2], com_interrupt);
      end
      rd(A_DATA, 1'b1, v);
      n_run++;
      if (v !== b) begin
        n_fail++;
        $display("FAIL rx_data got %h want %h", v, b);
      end
      repeat (2) @(negedge clk);
      rd(A_STAT, 1'b0, v);
      n_run++;
      if (v[2] !== 1'b0 || com_interrupt !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_cleared got %b/%b want 0/0",
                 v[2], com_interrupt);
      end
    end
    wr(A_CTRL, 8'h00);
  endtask

  task automatic test_overrun_frame_err;
    logic [7:0] mq [$];
    logic [7:0] b;
    logic [7:0] v;
    logic [7:0] e;
    bit         ovr;
    ovr = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1);
      if (mq.size() < DEPTH) mq.push_back(b);
      else ovr = 1'b1;
    end
    rd(A_STAT, 1'b1, v);
    n_run++;
    if (v[4] !== ovr || v[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set ovr=%b full=%b want %b/1",
               v[4], v[3], ovr);
    end
    rd(A_STAT, 1'b0, v);
    n_run++;
    if (v[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear got %b want 0", v[4]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = mq.pop_front();
      rd(A_DATA, 1'b1, v);
      n_run++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL rx_order%0d got %h want %h", i, v, e);
      end
    end
    rx_send(8'($urandom), 1'b0);
    rd(A_STAT, 1'b1, v);
    n_run++;
    if (v[5] !== 1'b1 || v[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err fe=%b valid=%b want 1/0", v[5], v[2]);
    end
    rd(A_STAT, 1'b0, v);
    n_run++;
    if (v[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_clear got %b want 0", v[5]);
    end
  endtask

  task automatic test_simul_rw;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  v;
    logic [39:0] w;
    bit          ok;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    rx_send(b1, 1'b1);
    fork
      begin
        @(negedge clk);
        com_addr  = A_DATA;
        com_wr    = b2;
        com_wr_en = 1'b1;
        com_rd_en = 1'b1;
        #1 v = com_rd;
        @(posedge clk);
        #1;
        com_wr_en = 1'b0;
        com_rd_en = 1'b0;
      end
      capture(6, w, ok);
    join
    n_run++;
    if (v !== b1 || !ok || w !== tx_wave(b2)) begin
      n_fail++;
      $display("FAIL simul_rw rd=%h want %h frame=%h want %h",
               v, b1, w, tx_wave(b2));
    end
    rd(A_STAT, 1'b0, v);
    n_run++;
    if (v[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_rw_pop valid=%b want 0", v[2]);
    end
  endtask

`ifdef COM_UART_LOOPBACK_EN
  task automatic test_loopback;
    logic [7:0] b;
    logic [7:0] v;
    bit         hi;
    b = 8'($urandom);
    wr(A_CTRL, 8'h04);
    hi = 1'b1;
    fork
      wr(A_DATA, b);
      repeat (60) begin
        @(negedge clk);
        if (uart_txd !== 1'b1) hi = 1'b0;
      end
    join
    rd(A_DATA, 1'b1, v);
    n_run++;
    if (!hi || v !== b) begin
      n_fail++;
      $display("FAIL loopback hi=%0d got %h want %h", hi, v, b);
    end
    wr(A_CTRL, 8'h00);
  endtask
`endif

  task automatic test_reset_mid_tx;
    logic [7:0] v;
    wr(A_DATA, 8'h00);
    repeat (12) @(negedge clk);
    n_run++;
    if (uart_txd !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_tx_low got %b want 0", uart_txd);
    end
    #2 rst = 1'b0;
    #1;
    n_run++;
    if (uart_txd !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_txd got %b want 1", uart_txd);
    end
    @(negedge clk);
    rst = 1'b1;
    rd(A_STAT, 1'b0, v);
    n_run++;
    if (v !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_status got %h want 02", v);
    end
    rd(A_BAUD, 1'b0, v);
    n_run++;
    if (v !== 8'h0F) begin
      n_fail++;
      $display("FAIL reset_baud got %h want 0f", v);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_irq_tx();
    test_tx_frame();
    test_back_to_back();
    test_rx_frame();
    test_overrun_frame_err();
    test_simul_rw();
`ifdef COM_UART_LOOPBACK_EN
    test_loopback();
`endif
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
